// File: rtl/fpu_cmp_lane_pipe.sv
// Per-channel op/valid tracking pipeline for the split high/low FPU datapath.
// At stage DEPTH each channel picks its status flags from the high half, low half or both.

`ifndef fop_cmpDH
`define fop_cmpDH 8'h5A
`endif

module fpu_cmp_lane #(
  parameter int          DEPTH   = 4,
  parameter int          OPW     = 13,
  parameter int          FLAGW   = 6,
  parameter logic [7:0]  CMPH_OP = `fop_cmpDH,
  parameter logic [7:0]  CMPB_OP = 8'hFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   op_in,
  input  logic             op_vld,
  input  logic             kill,
  input  logic [FLAGW-1:0] flg_h,
  input  logic [FLAGW-1:0] flg_l,
  input  logic             sticky_clr,
  output logic [FLAGW-1:0] fus,
  output logic             fus_vld,
  output logic [FLAGW-1:0] sticky,
  output logic             busy
);

  logic [DEPTH:1][OPW-1:0] op_pipe;
  logic [DEPTH:1]          vld_pipe;
  logic [7:0]              opc;

  assign opc     = op_pipe[DEPTH][7:0];
  assign fus_vld = vld_pipe[DEPTH];
  assign busy    = |vld_pipe;

  // Only the low byte of the op steers the select; the rest rides along for alignment.
  if (OPW > 8) begin : g_op_hi
    logic op_hi_unused;
    assign op_hi_unused = ^op_pipe[DEPTH][OPW-1:8];
  end

  // High-select wins when both codes coincide.
  always_comb begin
    fus = '0;
    if (vld_pipe[DEPTH]) begin
      if (opc == CMPH_OP)      fus = flg_h;
      else if (opc == CMPB_OP) fus = flg_h | flg_l;
      else                     fus = flg_l;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_pipe  <= '0;
      vld_pipe <= '0;
      sticky   <= '0;
    end else begin
      op_pipe[1]  <= op_in;
      vld_pipe[1] <= op_vld & ~kill;
      for (int s = 2; s <= DEPTH; s++) begin
        op_pipe[s]  <= op_pipe[s-1];
        vld_pipe[s] <= vld_pipe[s-1] & ~kill;
      end
      // fus is zero when nothing retires, so the clear path needs no extra gating.
      if (sticky_clr)   sticky <= fus;
      else if (fus_vld) sticky <= sticky | fus;
    end
  end

endmodule

module fpu_cmp_lane_pipe #(
  parameter int          NCH     = 3,
  parameter int          DEPTH   = 4,
  parameter int          OPW     = 13,
  parameter int          FLAGW   = 6,
  parameter logic [7:0]  CMPH_OP = `fop_cmpDH,
  parameter logic [7:0]  CMPB_OP = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*OPW-1:0]   op_in,
  input  logic [NCH-1:0]       op_vld,
  input  logic [NCH-1:0]       kill,
  input  logic [NCH*FLAGW-1:0] flgH,
  input  logic [NCH*FLAGW-1:0] flgL,
  input  logic                 sticky_clr,
  output logic [NCH*FLAGW-1:0] fus,
  output logic [NCH-1:0]       fus_vld,
  output logic [NCH*FLAGW-1:0] sticky,
  output logic [NCH-1:0]       busy
);

  logic [NCH-1:0][OPW-1:0]   op_a;
  logic [NCH-1:0][FLAGW-1:0] flg_h_a, flg_l_a, fus_a, sticky_a;

  assign op_a    = op_in;
  assign flg_h_a = flgH;
  assign flg_l_a = flgL;
  assign fus     = fus_a;
  assign sticky  = sticky_a;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    fpu_cmp_lane #(
      .DEPTH(DEPTH), .OPW(OPW), .FLAGW(FLAGW),
      .CMPH_OP(CMPH_OP), .CMPB_OP(CMPB_OP)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .op_in      (op_a[c]),
      .op_vld     (op_vld[c]),
      .kill       (kill[c]),
      .flg_h      (flg_h_a[c]),
      .flg_l      (flg_l_a[c]),
      .sticky_clr (sticky_clr),
      .fus        (fus_a[c]),
      .fus_vld    (fus_vld[c]),
      .sticky     (sticky_a[c]),
      .busy       (busy[c])
    );
  end

endmodule

// File: tb/tb_fpu_cmp_lane_pipe.sv
// Scoreboard bench for fpu_cmp_lane_pipe: driver pushes expected retires, monitor checks at negedge.

module tb_fpu_cmp_lane_pipe;
  localparam int NCH = 3, D = 4, OPW = 13, FW = 6, MAXC = 1024;
  localparam logic [7:0] CH = 8'h5A, CB = 8'hFF;

  logic                clk = 0, rst = 0, sticky_clr = 0;
  logic [NCH*OPW-1:0]  op_in = '0;
  logic [NCH-1:0]      op_vld = '0, kill = '0, fus_vld, busy;
  logic [NCH*FW-1:0]   flgH = '0, flgL = '0, fus, sticky;

  fpu_cmp_lane_pipe #(.NCH(NCH), .DEPTH(D), .OPW(OPW), .FLAGW(FW), .CMPH_OP(CH), .CMPB_OP(CB)) dut (
    .clk(clk), .rst(rst), .op_in(op_in), .op_vld(op_vld), .kill(kill),
    .flgH(flgH), .flgL(flgL), .sticky_clr(sticky_clr),
    .fus(fus), .fus_vld(fus_vld), .sticky(sticky), .busy(busy));

  always #5 clk = ~clk;

  typedef struct { int rc; logic [FW-1:0] f; } ent_t;
  ent_t          q [NCH][$];
  logic [FW-1:0] st_m [NCH];
  logic [NCH*FW-1:0] fh [0:MAXC-1];
  logic [NCH*FW-1:0] fl [0:MAXC-1];
  int cyc = 0, checks = 0, errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s ch%0d cyc=%0d act=%0h exp=%0h", nm, c, cyc, act, exp);
    end
  endtask

  // Reference selection straight from the op-code rules.
  function automatic logic [FW-1:0] sel(input logic [OPW-1:0] op, input logic [FW-1:0] h, input logic [FW-1:0] l);
    if (op[7:0] == CH) return h;
    if (op[7:0] == CB) return h | l;
    return l;
  endfunction

  function automatic logic [OPW-1:0] rnd_op();
    logic [OPW-1:0] o;
    o = OPW'($urandom);
    case ($urandom_range(0, 2))
      0: o[7:0] = CH;
      1: o[7:0] = CB;
      default: ;
    endcase
    return o;
  endfunction

  // One cycle of stimulus; valid un-killed issues are queued with their expected flags.
  task automatic issue(input logic rv, input logic [NCH-1:0] v, input logic [NCH*OPW-1:0] ops,
                       input logic [NCH-1:0] k, input logic clr);
    int n;
    @(posedge clk); #1;
    n = cyc;
    rst = rv; op_vld = v; op_in = ops; kill = k; sticky_clr = clr;
    flgH = fh[n]; flgL = fl[n];
    if (rv)
      for (int c = 0; c < NCH; c++)
        if (v[c] && !k[c]) begin
          ent_t e;
          e.rc = n + D;
          e.f  = sel(ops[c*OPW +: OPW], fh[n+D][c*FW +: FW], fl[n+D][c*FW +: FW]);
          q[c].push_back(e);
        end
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) issue(1'b1, '0, '0, '0, 1'b0);
  endtask

  task automatic set_flags(input int from, input int len, input logic [FW-1:0] h, input logic [FW-1:0] l);
    for (int i = from; i < from + len; i++) begin
      fh[i] = {NCH{h}};
      fl[i] = {NCH{l}};
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_fus", 0, 32'(fus), 0);
      chk("rst_fus_vld", 0, 32'(fus_vld), 0);
      chk("rst_sticky", 0, 32'(sticky), 0);
      chk("rst_busy", 0, 32'(busy), 0);
      for (int c = 0; c < NCH; c++) begin
        q[c].delete();
        st_m[c] = '0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        logic ev, eb;
        logic [FW-1:0] ef;
        ev = (q[c].size() > 0) && (q[c][0].rc == cyc);
        ef = ev ? q[c][0].f : '0;
        eb = 1'b0;
        foreach (q[c][i]) if (q[c][i].rc >= cyc && q[c][i].rc <= cyc + D - 1) eb = 1'b1;
        chk("fus_vld", c, 32'(fus_vld[c]), 32'(ev));
        chk("fus", c, 32'(fus[c*FW +: FW]), 32'(ef));
        chk("busy", c, 32'(busy[c]), 32'(eb));
        chk("sticky", c, 32'(sticky[c*FW +: FW]), 32'(st_m[c]));
        if (ev) void'(q[c].pop_front());
        st_m[c] = sticky_clr ? ef : (st_m[c] | ef);
        if (kill[c]) q[c].delete();
      end
    end
  end

  initial begin
    logic [NCH*OPW-1:0] ops;
    for (int i = 0; i < MAXC; i++) begin
      fh[i] = (NCH*FW)'($urandom);
      fl[i] = (NCH*FW)'($urandom);
    end
    for (int c = 0; c < NCH; c++) st_m[c] = '0;

    // Reset held with random inputs, then release.
    for (int i = 0; i < 3; i++) issue(1'b0, NCH'($urandom), (NCH*OPW)'({$urandom, $urandom}), '0, 1'b0);
    idle(2);

    // High / low / merge select with fixed flags.
    set_flags(cyc + 1, 12, 6'h15, 6'h2A);
    issue(1'b1, 3'b111, {13'h0FF, 13'h010, 13'h05A}, '0, 1'b0);
    idle(D + 2);
    issue(1'b1, 3'b001, {13'h000, 13'h000, 13'h05A}, '0, 1'b0);
    idle(D + 2);

    // Kill on ch1 with ch0/ch2 traffic alongside.
    issue(1'b1, 3'b111, {13'h0FF, 13'h010, 13'h05A}, '0, 1'b0);
    issue(1'b1, 3'b111, {13'h033, 13'h05A, 13'h0FF}, '0, 1'b0);
    issue(1'b1, 3'b000, '0, 3'b010, 1'b0);
    idle(D + 2);

    // Sticky: accumulate, clear with same-cycle retire, clear alone.
    issue(1'b1, '0, '0, '0, 1'b1);
    fl[cyc+1+D][FW-1:0] = 6'h01;
    fl[cyc+2+D][FW-1:0] = 6'h04;
    issue(1'b1, 3'b001, {26'h0, 13'h010}, '0, 1'b0);
    issue(1'b1, 3'b001, {26'h0, 13'h010}, '0, 1'b0);
    idle(D + 1);
    fl[cyc+1+D][FW-1:0] = 6'h02;
    issue(1'b1, 3'b001, {26'h0, 13'h010}, '0, 1'b0);
    idle(D - 1);
    issue(1'b1, '0, '0, '0, 1'b1);
    idle(1);
    issue(1'b1, '0, '0, '0, 1'b1);
    idle(2);

    // Back-to-back issue on every channel.
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < NCH; c++) ops[c*OPW +: OPW] = rnd_op();
      issue(1'b1, '1, ops, '0, 1'b0);
    end
    idle(D + 1);

    // Random traffic with kills, clears and a mid-run reset.
    for (int i = 0; i < 300; i++) begin
      logic [NCH-1:0] v, k;
      for (int c = 0; c < NCH; c++) begin
        ops[c*OPW +: OPW] = rnd_op();
        v[c] = $urandom_range(0, 3) != 0;
        k[c] = $urandom_range(0, 15) == 0;
      end
      issue(!(i >= 150 && i < 152), v, ops, k, $urandom_range(0, 19) == 0);
    end
    idle(D + 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fpu_cmp_lane_pipe.md
# fpu_cmp_lane_pipe

Parametrised per-channel op-tracking pipeline for the split high/low FPU datapath. It carries each channel's op code and a valid bit through DEPTH stages, aligned with the FPU halves. At the final stage it selects the channel's status flags from the high half, the low half, or both merged, based on the retiring op. It extends the fixed 3-channel, 4-stage, high/low select with:
- valid tracking;
- per-channel kill;
- a both-halves merge mode;
- per-channel sticky flag accumulation.

## Interface
Parameters:
- NCH, 3, number of FPU issue channels.
- DEPTH, 4, pipeline stages from op issue to flag select (≥1).
- OPW, 13, op code width.
- FLAGW, 6, status flag width per channel.
- CMPH_OP, `fop_cmpDH, op[7:0] code that selects high-half flags.
- CMPB_OP, 8'hFF, op[7:0] code that selects the high|low merged flags.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- op_in  in  NCH*OPW  issued op; channel c occupies [c*OPW +: OPW].
- op_vld  in  NCH  op_in[c] is a real issue this cycle.
- kill  in  NCH  cancel all in-flight ops of channel c.
- flgH  in  NCH*FLAGW  high-half status flags, aligned to stage DEPTH.
- flgL  in  NCH*FLAGW  low-half status flags, aligned to stage DEPTH.
- sticky_clr  in  1  clear all sticky flags.
- fus  out  NCH*FLAGW  selected status flags for each channel's retiring op.
- fus_vld  out  NCH  a valid op retires on channel c this cycle.
- sticky  out  NCH*FLAGW  accumulated flags per channel.
- busy  out  NCH  channel c has any valid op in stages 1..DEPTH.

## Operation
Pipeline state:
- Per channel, stages s=1..DEPTH each hold op[s] (OPW bits) and v[s] (1 bit).
- The op fields shift every cycle unconditionally: op[1]<=op_in, op[s]<=op[s-1].
- The valid bits shift as v[1]<=op_vld[c] & ~kill[c] and v[s]<=v[s-1] & ~kill[c].

Kill:
- kill[c] clears every valid bit of channel c at the edge, including the same-cycle capture.
- It does not mask that cycle's fus or fus_vld, because the stage-DEPTH op has already retired.
- Channels are fully independent.

Select logic (combinational, from stage DEPTH), per channel:
- If v[DEPTH]=0, fus=0.
- Else if op[DEPTH][7:0]==CMPH_OP, fus=flgH.
- Else if op[DEPTH][7:0]==CMPB_OP, fus=flgH|flgL.
- Else fus=flgL.
- CMPH_OP takes priority if the two codes are equal.
- fus_vld[c]=v[DEPTH].

Sticky flags, updated at the edge per channel:
- sticky_clr=1: sticky <= (fus_vld ? fus : 0). The clear applies first, then the same-cycle retire accumulates.
- Else if fus_vld: sticky <= sticky | fus.
- Else: hold.

Busy: busy[c] = OR of v[1..DEPTH] for channel c (combinational).

Reset (rst=0, asynchronous):
- All v, op and sticky go to 0, so every output is 0: fus, fus_vld, sticky, busy.
- Reset asserted mid-operation drops all in-flight ops with no retire.
- The first capture happens on the first rising edge after rst rises.

## Timing
- Latency: an op presented with op_vld in cycle t appears at stage DEPTH in cycle t+DEPTH. fus and fus_vld are valid in that cycle, combinational from registers plus flgH/flgL.
- Throughput: one op per channel per cycle, with no stall and no back-pressure.
- sticky reflects a retire from cycle t in cycle t+1.
- busy rises the cycle after the capture edge. It falls the cycle after the last valid op leaves stage DEPTH, or the cycle after a kill.
- Boundary, DEPTH=1: op_in is captured directly into the select stage.
- Boundary, simultaneous op_vld and kill on a channel: the new op is dropped.

## Test plan
- Reset: hold rst=0 with random inputs → fus, fus_vld, sticky and busy are all 0. Release rst → nothing retires until DEPTH cycles after the first op_vld.
- Latency and high select: DEPTH=4, CMPH_OP=8'h5A, ch0 op 13'h05A valid in cycle 0, flgH=6'h15, flgL=6'h2A → fus_vld[0]=1 and fus ch0=6'h15 in cycle 4 only. busy[0] is high in cycles 1-4.
- Low and merge select: ch1 op 8'h10 → fus=flgL=6'h2A. ch2 op CMPB_OP=8'hFF → fus=6'h3F. Non-retiring channels show fus=0.
- Kill: ch1 ops valid in cycles 0 and 1, kill[1] in cycle 2 → fus_vld[1] never asserts and busy[1]=0 from cycle 3. Ch0 and ch2 traffic is unaffected.
- Sticky: two ch0 retires with flags 6'h01 then 6'h04 → sticky ch0=6'h05. sticky_clr in the same cycle as a retire with 6'h02 → sticky=6'h02. sticky_clr with no retire → 0.
- Back-to-back: all three channels issue every cycle for 20 cycles with distinct ops → retirements arrive in issue order with the correct per-op selection. busy stays high throughout and sticky equals the OR of all retired flags.
